// File: rtl/bp_resolve_queue.sv
// In-flight branch tracker: queues fetch-time predictions, checks them at M,
// and drives the registered predictor-update port plus the mispredict redirect.
module bp_resolve_queue #(
    parameter int unsigned BHT_DEPTH = 3,
    parameter int unsigned Q_DEPTH   = 4,
    parameter int unsigned PC_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pushF,
    input  logic                       predF,
    input  logic [BHT_DEPTH-1:0]       hashed_pcF,
    input  logic [BHT_DEPTH-1:0]       hashed_pc2F,
    input  logic [PC_W-1:0]            fallthruF,
    input  logic                       resolveM,
    input  logic                       takenM,
    input  logic [PC_W-1:0]            targetM,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Q_DEPTH):0]   count,
    output logic                       branchM,
    output logic                       pcsrcM,
    output logic [BHT_DEPTH-1:0]       hashed_pcM,
    output logic [BHT_DEPTH-1:0]       hashed_pc2M,
    output logic                       mispredict,
    output logic [PC_W-1:0]            redirect_pc,
    output logic                       err
);

    localparam int unsigned PTR_W = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic                 pred_mem [Q_DEPTH];
    logic [BHT_DEPTH-1:0] hpc_mem  [Q_DEPTH];
    logic [BHT_DEPTH-1:0] hpc2_mem [Q_DEPTH];
    logic [PC_W-1:0]      ft_mem   [Q_DEPTH];

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_q, err_d;
    logic                 branch_q, branch_d;
    logic                 pcsrc_q, pcsrc_d;
    logic [BHT_DEPTH-1:0] hpc_q, hpc_d, hpc2_q, hpc2_d;
    logic                 mis_q, mis_d;
    logic [PC_W-1:0]      rpc_q, rpc_d;

    logic full_w, empty_w, pop, udf, ovf, push, mis, we;

    assign full_w  = (count_q == CNT_W'(Q_DEPTH));
    assign empty_w = (count_q == '0);
    assign pop     = resolveM && !empty_w;
    assign udf     = resolveM && empty_w;
    assign ovf     = pushF && full_w && !pop;
    // An underflowing resolve makes the whole cycle an error, so its push is dropped too.
    assign push    = pushF && (!full_w || pop) && !udf;
    assign mis     = pop && (pred_mem[head_q] != takenM);
    assign we      = push && !flush && !mis;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        err_d    = err_q;
        branch_d = 1'b0;
        pcsrc_d  = 1'b0;
        hpc_d    = '0;
        hpc2_d   = '0;
        mis_d    = 1'b0;
        rpc_d    = '0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (ovf || udf) begin
                err_d = 1'b1;
            end
            if (pop) begin
                branch_d = 1'b1;
                pcsrc_d  = takenM;
                hpc_d    = hpc_mem[head_q];
                hpc2_d   = hpc2_mem[head_q];
            end
            if (mis) begin
                mis_d   = 1'b1;
                rpc_d   = takenM ? targetM : ft_mem[head_q];
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                if (push) begin
                    tail_d = tail_q + PTR_W'(1);
                end
                count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            branch_q <= 1'b0;
            pcsrc_q  <= 1'b0;
            hpc_q    <= '0;
            hpc2_q   <= '0;
            mis_q    <= 1'b0;
            rpc_q    <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
            branch_q <= branch_d;
            pcsrc_q  <= pcsrc_d;
            hpc_q    <= hpc_d;
            hpc2_q   <= hpc2_d;
            mis_q    <= mis_d;
            rpc_q    <= rpc_d;
        end
    end

    // Entry storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (we) begin
            pred_mem[tail_q] <= predF;
            hpc_mem[tail_q]  <= hashed_pcF;
            hpc2_mem[tail_q] <= hashed_pc2F;
            ft_mem[tail_q]   <= fallthruF;
        end
    end

    assign full        = full_w;
    assign empty       = empty_w;
    assign count       = count_q;
    assign err         = err_q;
    assign branchM     = branch_q;
    assign pcsrcM      = pcsrc_q;
    assign hashed_pcM  = hpc_q;
    assign hashed_pc2M = hpc2_q;
    assign mispredict  = mis_q;
    assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Scoreboard bench for bp_resolve_queue: directed pushes/resolves with
// hand-computed update/redirect responses checked by an independent monitor.
module tb_bp_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        pushF, predF, resolveM, takenM, flush;
    logic [2:0]  hashed_pcF, hashed_pc2F;
    logic [31:0] fallthruF, targetM;
    logic        full, empty, branchM, pcsrcM, mispredict, err;
    logic [2:0]  count, hashed_pcM, hashed_pc2M;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    bp_resolve_queue #(.BHT_DEPTH(3), .Q_DEPTH(4), .PC_W(32)) dut (
        .clk(clk), .rst(rst),
        .pushF(pushF), .predF(predF), .hashed_pcF(hashed_pcF),
        .hashed_pc2F(hashed_pc2F), .fallthruF(fallthruF),
        .resolveM(resolveM), .takenM(takenM), .targetM(targetM), .flush(flush),
        .full(full), .empty(empty), .count(count),
        .branchM(branchM), .pcsrcM(pcsrcM),
        .hashed_pcM(hashed_pcM), .hashed_pc2M(hashed_pc2M),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .err(err)
    );

    typedef struct packed {
        logic        br;
        logic        pcsrc;
        logic [2:0]  h1;
        logic [2:0]  h2;
        logic        mis;
        logic [31:0] rpc;
    } resp_t;

    resp_t sb[$];
    resp_t got, exp_r;
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic resp_t mk(input logic pc, input logic [2:0] a, input logic [2:0] b,
                                 input logic m, input logic [31:0] r);
        resp_t x;
        x.br = 1'b1; x.pcsrc = pc; x.h1 = a; x.h2 = b; x.mis = m; x.rpc = r;
        return x;
    endfunction

    function automatic logic [2:0]  eh (input int j); return 3'(j);            endfunction
    function automatic logic [2:0]  eh2(input int j); return 3'(j * 5 + 3);    endfunction
    function automatic logic [31:0] ef (input int j); return 32'h100 + 32'(j * 8); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic pd, input logic [2:0] a, input logic [2:0] b,
                        input logic [31:0] f, input logic r, input logic t,
                        input logic [31:0] g, input logic fl);
        pushF = p; predF = pd; hashed_pcF = a; hashed_pc2F = b; fallthruF = f;
        resolveM = r; takenM = t; targetM = g; flush = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every update/redirect the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && (branchM || mispredict)) begin
            got = '{branchM, pcsrcM, hashed_pcM, hashed_pc2M, mispredict, redirect_pc};
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_update: got %h expected none", got);
            end else begin
                exp_r = sb.pop_front();
                if (got !== exp_r) begin
                    n_fail++;
                    $display("FAIL update_resp: got %h expected %h", got, exp_r);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        pushF = 0; predF = 0; hashed_pcF = 0; hashed_pc2F = 0; fallthruF = 0;
        resolveM = 0; takenM = 0; targetM = 0; flush = 0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_branch", 32'(branchM), 0);
        chk("rst_mis", 32'(mispredict), 0);
        @(negedge clk);
        rst = 1'b1;

        // push then correct resolve
        step(1, 1, 3, 5, 32'h108, 0, 0, 0, 0);
        chk("t1_count", 32'(count), 1);
        chk("t1_empty", 32'(empty), 0);
        sb.push_back(mk(1, 3, 5, 0, 0));
        step(0, 0, 0, 0, 0, 1, 1, 32'h5555, 0);
        chk("t1_count_after", 32'(count), 0);

        // not-taken mispredict with younger entries and a dropped same-cycle push
        step(1, 1, 1, 2, 32'h1008, 0, 0, 0, 0);
        step(1, 0, 2, 3, 32'h2008, 0, 0, 0, 0);
        step(1, 1, 4, 4, 32'h3008, 0, 0, 0, 0);
        chk("t2_count3", 32'(count), 3);
        sb.push_back(mk(0, 1, 2, 1, 32'h1008));
        step(1, 1, 7, 7, 32'h9008, 1, 0, 32'h7777, 0);
        chk("t2_count_clr", 32'(count), 0);
        chk("t2_empty", 32'(empty), 1);
        idle();
        chk("t2_pulse_end", 32'(mispredict), 0);

        // taken mispredict
        step(1, 0, 6, 7, 32'h4008, 0, 0, 0, 0);
        sb.push_back(mk(1, 6, 7, 1, 32'h2000));
        step(0, 0, 0, 0, 0, 1, 1, 32'h2000, 0);
        chk("t3_count", 32'(count), 0);

        // fill, overflow, push+pop at full, wrap
        for (int j = 0; j < 4; j++) step(1, 1, eh(j), eh2(j), ef(j), 0, 0, 0, 0);
        chk("t4_full", 32'(full), 1);
        chk("t4_count4", 32'(count), 4);
        chk("t4_err_pre", 32'(err), 0);
        step(1, 1, 6, 6, 32'hdead, 0, 0, 0, 0);
        chk("t4_ovf_err", 32'(err), 1);
        chk("t4_ovf_count", 32'(count), 4);
        sb.push_back(mk(1, eh(0), eh2(0), 0, 0));
        step(1, 1, eh(4), eh2(4), ef(4), 1, 1, 32'h1234, 0);
        chk("t4_pp_count", 32'(count), 4);
        chk("t4_pp_full", 32'(full), 1);
        for (int k = 0; k < 10; k++) begin
            sb.push_back(mk(1, eh(1 + k), eh2(1 + k), 0, 0));
            step(1, 1, eh(5 + k), eh2(5 + k), ef(5 + k), 1, 1, 32'h1234, 0);
            chk("t4_wrap_count", 32'(count), 4);
        end
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(1, eh(11 + k), eh2(11 + k), 0, 0));
            step(0, 0, 0, 0, 0, 1, 1, 32'h1234, 0);
            chk("t4_drain_count", 32'(count), 32'(3 - k));
        end
        chk("t4_drain_empty", 32'(empty), 1);

        // async reset mid-stream while an update is on the port
        step(1, 1, 5, 6, 32'h5008, 0, 0, 0, 0);
        step(1, 1, 2, 1, 32'h6008, 0, 0, 0, 0);
        step(1, 0, 3, 3, 32'h7008, 0, 0, 0, 0);
        pushF = 0; resolveM = 1; takenM = 1; targetM = 32'h6000;
        @(posedge clk);
        #2;
        chk("t5_pre_branch", 32'(branchM), 1);
        chk("t5_pre_h1", 32'(hashed_pcM), 5);
        chk("t5_pre_count", 32'(count), 2);
        rst = 1'b0;
        #1;
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_err", 32'(err), 0);
        chk("t5_branch", 32'(branchM), 0);
        chk("t5_pcsrc", 32'(pcsrcM), 0);
        chk("t5_h1", 32'(hashed_pcM), 0);
        chk("t5_h2", 32'(hashed_pc2M), 0);
        chk("t5_mis", 32'(mispredict), 0);
        chk("t5_rpc", redirect_pc, 0);
        resolveM = 0; takenM = 0; targetM = 0;
        @(negedge clk);
        rst = 1'b1;

        // underflow with a same-cycle push
        step(1, 1, 2, 2, 32'h8008, 1, 1, 0, 0);
        chk("t6_err", 32'(err), 1);
        chk("t6_branch", 32'(branchM), 0);
        chk("t6_count", 32'(count), 0);

        // flush with a same-cycle mispredicting resolve and push
        step(1, 1, 1, 1, 32'ha008, 0, 0, 0, 0);
        step(1, 1, 2, 2, 32'hb008, 0, 0, 0, 0);
        step(1, 1, 3, 3, 32'hc008, 0, 0, 0, 0);
        chk("t7_count3", 32'(count), 3);
        step(1, 1, 4, 4, 32'hd008, 1, 0, 32'h1111, 1);
        chk("t7_count", 32'(count), 0);
        chk("t7_empty", 32'(empty), 1);
        chk("t7_branch", 32'(branchM), 0);
        chk("t7_mis", 32'(mispredict), 0);
        step(1, 1, 7, 1, 32'he008, 0, 0, 0, 0);
        sb.push_back(mk(1, 7, 1, 0, 0));
        step(0, 0, 0, 0, 0, 1, 1, 32'h3333, 0);
        chk("t7_post_count", 32'(count), 0);

        idle();
        idle();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
